// File: rtl/cafe_pkg.sv
// Shared constants for the coffee machine: states, coin codes, price codes.
package cafe_pkg;

    localparam int unsigned UNIT_COLONES = 250;
    localparam int unsigned CRED_W       = 5;
    localparam int unsigned PRECIO_W     = 4;
    localparam int unsigned COIN_W       = 2;
    localparam int unsigned STATE_W      = 3;

    // Controller states
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_COBRANDO = 3'd1,
        ST_PAGADO   = 3'd2,
        ST_DEVOLVER = 3'd3,
        ST_ESPERA   = 3'd4
    } pago_state_e;

    // Coin acceptor codes
    localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
    localparam logic [COIN_W-1:0] COIN_250  = 2'b01;
    localparam logic [COIN_W-1:0] COIN_500  = 2'b10;
    localparam logic [COIN_W-1:0] COIN_1000 = 2'b11;

    localparam logic [2:0] COIN_250_UNID  = 3'd1;
    localparam logic [2:0] COIN_500_UNID  = 3'd2;
    localparam logic [2:0] COIN_1000_UNID = 3'd4;

    // Price codes shared with the drink FSM
    localparam logic [PRECIO_W-1:0] PRECIO_500  = 4'd1;
    localparam logic [PRECIO_W-1:0] PRECIO_1000 = 4'd2;
    localparam logic [PRECIO_W-1:0] PRECIO_1500 = 4'd3;
    localparam logic [PRECIO_W-1:0] PRECIO_750  = 4'd4;
    localparam logic [PRECIO_W-1:0] PRECIO_1250 = 4'd5;
    localparam logic [PRECIO_W-1:0] PRECIO_1750 = 4'd6;
    localparam logic [PRECIO_W-1:0] PRECIO_2000 = 4'd7;
    localparam logic [PRECIO_W-1:0] PRECIO_2250 = 4'd8;

    // Coin value in 250 units; invalid coin is worth nothing
    function automatic logic [2:0] coin_units(input logic [COIN_W-1:0] t);
        logic [2:0] u;
        case (t)
            COIN_250:  u = COIN_250_UNID;
            COIN_500:  u = COIN_500_UNID;
            COIN_1000: u = COIN_1000_UNID;
            default:   u = 3'd0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/cafe_precio_dec.sv
// Price code to price units (250 each) decoder, also used by the display.
module cafe_precio_dec
    import cafe_pkg::*;
(
    input  logic [PRECIO_W-1:0] precio_code_i,
    output logic [PRECIO_W-1:0] precio_unid_c,
    output logic                precio_valid_c
);

    // Lookup of the fixed price table
    always_comb begin
        precio_unid_c  = 4'd0;
        precio_valid_c = 1'b1;
        case (precio_code_i)
            PRECIO_500:  precio_unid_c = 4'd2;
            PRECIO_1000: precio_unid_c = 4'd4;
            PRECIO_1500: precio_unid_c = 4'd6;
            PRECIO_750:  precio_unid_c = 4'd3;
            PRECIO_1250: precio_unid_c = 4'd5;
            PRECIO_1750: precio_unid_c = 4'd7;
            PRECIO_2000: precio_unid_c = 4'd8;
            PRECIO_2250: precio_unid_c = 4'd9;
            default:     precio_valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/cafe_pago_ctrl.sv
// Payment controller: accumulates coins against a latched price, pulses
// pago_recibido on completion, refunds on cancel or inactivity.
module cafe_pago_ctrl
    import cafe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PRECIO_W-1:0] precio_code,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_type,
    input  logic                cancel,
    output logic                pago_recibido,
    output logic                cambio_valid,
    output logic [CRED_W-1:0]   cambio,
    output logic [CRED_W-1:0]   credito,
    output logic                coin_reject
);

    localparam int unsigned TIMER_W = 8;

    pago_state_e         state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [PRECIO_W-1:0] precio_q, precio_d;
    logic [CRED_W-1:0]   credito_q, credito_d;
    logic [CRED_W-1:0]   cambio_q, cambio_d;
    logic                pago_q, pago_d;
    logic                cambio_valid_q, cambio_valid_d;
    logic                reject_q, reject_d;

    logic [PRECIO_W-1:0] precio_unid_c;
    logic                precio_valid_c;
    logic                coin_ok_c;
    logic [CRED_W-1:0]   suma_c;

    cafe_precio_dec u_precio_dec (
        .precio_code_i  (precio_code),
        .precio_unid_c  (precio_unid_c),
        .precio_valid_c (precio_valid_c)
    );

    // Credit including the coin presented this cycle (max 8 + 4, fits in 5 bits)
    always_comb begin
        coin_ok_c = coin_valid && (coin_type != COIN_NONE);
        suma_c    = credito_q + (coin_ok_c ? CRED_W'(coin_units(coin_type)) : CRED_W'(0));
    end

    // Next-state and registered-output values
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        precio_d       = precio_q;
        credito_d      = credito_q;
        cambio_d       = '0;
        pago_d         = 1'b0;
        cambio_valid_d = 1'b0;
        reject_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                credito_d = '0;
                timer_d   = '0;
                reject_d  = coin_valid;
                if (precio_valid_c) begin
                    precio_d = precio_unid_c;
                    state_d  = ST_COBRANDO;
                end
            end
            ST_COBRANDO: begin
                reject_d  = coin_valid && !coin_ok_c;
                credito_d = suma_c;
                if (suma_c >= CRED_W'(precio_q)) begin
                    state_d        = ST_PAGADO;
                    pago_d         = 1'b1;
                    cambio_valid_d = 1'b1;
                    cambio_d       = suma_c - CRED_W'(precio_q);
                end else if (cancel ||
                             (!coin_ok_c && (timer_q == TIMER_W'(TIMEOUT_CICLOS - 1)))) begin
                    state_d        = ST_DEVOLVER;
                    cambio_valid_d = (suma_c != '0);
                    cambio_d       = suma_c;
                end else if (coin_ok_c) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_PAGADO, ST_DEVOLVER: begin
                credito_d = '0;
                timer_d   = '0;
                reject_d  = coin_valid;
                state_d   = ST_ESPERA;
            end
            ST_ESPERA: begin
                credito_d = '0;
                reject_d  = coin_valid;
                if (!precio_valid_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset discards any credit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            precio_q       <= '0;
            credito_q      <= '0;
            cambio_q       <= '0;
            pago_q         <= 1'b0;
            cambio_valid_q <= 1'b0;
            reject_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            precio_q       <= precio_d;
            credito_q      <= credito_d;
            cambio_q       <= cambio_d;
            pago_q         <= pago_d;
            cambio_valid_q <= cambio_valid_d;
            reject_q       <= reject_d;
        end
    end

    assign pago_recibido = pago_q;
    assign cambio_valid  = cambio_valid_q;
    assign cambio        = cambio_q;
    assign credito       = credito_q;
    assign coin_reject   = reject_q;

endmodule
